tmp_seq_mc: RTL and testbench

//   Parametrised multi-channel temperature-sensor sequencer; successor to the single-channel phase controller.

---
 rtl/tmp_pkg.sv | 23 ++
 rtl/tmp_phase_timer.sv | 41 ++++
 rtl/tmp_seq_mc.sv | 182 ++++++++++++++++++
 tb/tb_tmp_seq_mc.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmp_pkg.sv
// Shared types for the multi-channel temperature-sensor sequencer.
package tmp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRECHARGE,
        ST_BLANK1,
        ST_DIODE,
        ST_BLANK2,
        ST_BIGDIODE,
        ST_DONE
    } tmp_state_e;

    localparam int unsigned PH_MIN = 2;

    typedef struct packed {
        logic pii1;
        logic pii2;
        logic pi1;
        logic pi2;
    } tmp_phase_t;

endpackage

// File: rtl/tmp_phase_timer.sv
// Loadable phase-length down-counter: flags the 2nd cycle onward and the last cycle of a phase.
module tmp_phase_timer #(
    parameter int unsigned PH_W = 6
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic            load_i,
    input  logic [PH_W-1:0] len_i,
    output logic            second_o,
    output logic            last_o
);

    logic [PH_W-1:0] cnt_q, cnt_d;
    logic            second_q, second_d;

    always_comb begin
        cnt_d    = cnt_q;
        second_d = second_q;
        if (load_i) begin
            cnt_d    = len_i - 1'b1;
            second_d = 1'b0;
        end else if (cnt_q != '0) begin
            cnt_d    = cnt_q - 1'b1;
            second_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q    <= '0;
            second_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            second_q <= second_d;
        end
    end

    assign second_o = second_q;
    assign last_o   = (cnt_q == '0);

endmodule

// File: rtl/tmp_seq_mc.sv
// Multi-channel temperature-sensor sequencer: phase generation, charge-balance loop,
// snk event counting and channel stepping. All outputs are registered.
module tmp_seq_mc
    import tmp_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned PH_W  = 6,
    parameter int unsigned CYC_W = 8,
    parameter int unsigned ACC_W = 12,
    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             cont,
    input  logic             cmp,
    input  logic [PH_W-1:0]  ph_len,
    input  logic [CYC_W-1:0] n_cyc,
    output logic             PII1,
    output logic             PII2,
    output logic             PI1,
    output logic             PI2,
    output logic             src_n,
    output logic             snk,
    output logic             preChrg,
    output logic [N_CH-1:0]  ch_sel,
    output logic             busy,
    output logic             valid,
    output logic [ACC_W-1:0] result,
    output logic [CH_W-1:0]  result_ch
);

    tmp_state_e       state_q, state_d;
    logic [PH_W-1:0]  phlen_q, phlen_d;
    logic [CYC_W-1:0] ncyc_q, ncyc_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CH_W-1:0]  ch_q, ch_d;

    tmp_phase_t       ph_q, ph_d;
    logic             src_n_q, src_n_d;
    logic             snk_q, snk_d;
    logic             prechrg_q, prechrg_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [ACC_W-1:0] result_q, result_d;
    logic [CH_W-1:0]  result_ch_q, result_ch_d;
    logic [N_CH-1:0]  ch_sel_q, ch_sel_d;

    logic timer_load, ph_second, ph_last, arm;

    tmp_phase_timer #(.PH_W(PH_W)) u_timer (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .load_i   (timer_load),
        .len_i    (phlen_q),
        .second_o (ph_second),
        .last_o   (ph_last)
    );

    assign arm = start | cont;

    // Outputs are decoded from the current state and registered, so they trail the state by one cycle.
    always_comb begin
        state_d     = state_q;
        phlen_d     = phlen_q;
        ncyc_d      = ncyc_q;
        cyc_d       = cyc_q;
        acc_d       = acc_q;
        ch_d        = ch_q;
        ph_d        = '0;
        src_n_d     = 1'b1;
        snk_d       = 1'b0;
        prechrg_d   = 1'b0;
        busy_d      = (state_q != ST_IDLE);
        valid_d     = 1'b0;
        result_d    = result_q;
        result_ch_d = result_ch_q;
        ch_sel_d    = N_CH'(1) << ch_q;
        timer_load  = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (state_q == ST_DONE) begin
                    valid_d     = 1'b1;
                    result_d    = acc_q;
                    result_ch_d = ch_q;
                    ch_d        = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + 1'b1;
                    state_d     = ST_IDLE;
                end
                if (arm) begin
                    state_d = ST_PRECHARGE;
                    phlen_d = (ph_len < PH_W'(PH_MIN)) ? PH_W'(PH_MIN) : ph_len;
                    ncyc_d  = (n_cyc == '0) ? CYC_W'(1) : n_cyc;
                end
            end
            ST_PRECHARGE: begin
                prechrg_d = 1'b1;
                acc_d     = '0;
                cyc_d     = '0;
                state_d   = ST_BLANK1;
            end
            ST_BLANK1: begin
                timer_load = 1'b1;
                state_d    = ST_DIODE;
            end
            ST_DIODE: begin
                ph_d.pii1 = 1'b1;
                ph_d.pii2 = ph_second;
                if (ph_last) state_d = ST_BLANK2;
            end
            ST_BLANK2: begin
                timer_load = 1'b1;
                state_d    = ST_BIGDIODE;
            end
            ST_BIGDIODE: begin
                ph_d.pi1 = 1'b1;
                ph_d.pi2 = ph_second;
                if (ph_second) begin
                    if (cmp) snk_d   = ~snk_q;
                    else     src_n_d = ~src_n_q;
                    if (snk_d && !snk_q && acc_q != '1) acc_d = acc_q + 1'b1;
                end
                if (ph_last) begin
                    cyc_d   = cyc_q + 1'b1;
                    state_d = (cyc_d == ncyc_q) ? ST_DONE : ST_BLANK1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            phlen_q     <= PH_W'(PH_MIN);
            ncyc_q      <= CYC_W'(1);
            cyc_q       <= '0;
            acc_q       <= '0;
            ch_q        <= '0;
            ph_q        <= '0;
            src_n_q     <= 1'b1;
            snk_q       <= 1'b0;
            prechrg_q   <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            result_q    <= '0;
            result_ch_q <= '0;
            ch_sel_q    <= N_CH'(1);
        end else begin
            state_q     <= state_d;
            phlen_q     <= phlen_d;
            ncyc_q      <= ncyc_d;
            cyc_q       <= cyc_d;
            acc_q       <= acc_d;
            ch_q        <= ch_d;
            ph_q        <= ph_d;
            src_n_q     <= src_n_d;
            snk_q       <= snk_d;
            prechrg_q   <= prechrg_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            result_q    <= result_d;
            result_ch_q <= result_ch_d;
            ch_sel_q    <= ch_sel_d;
        end
    end

    assign PII1      = ph_q.pii1;
    assign PII2      = ph_q.pii2;
    assign PI1       = ph_q.pi1;
    assign PI2       = ph_q.pi2;
    assign src_n     = src_n_q;
    assign snk       = snk_q;
    assign preChrg   = prechrg_q;
    assign busy      = busy_q;
    assign valid     = valid_q;
    assign result    = result_q;
    assign result_ch = result_ch_q;
    assign ch_sel    = ch_sel_q;

endmodule

// File: tb/tb_tmp_seq_mc.sv
// Bench for tmp_seq_mc: vector table, hand sequences and random conversions against a cycle model.
module tb_tmp_seq_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       start, cont, cmp;
    logic [5:0] ph_len;
    logic [7:0] n_cyc;
    logic       PII1, PII2, PI1, PI2, src_n, snk, preChrg, busy, valid;
    logic [3:0] ch_sel;
    logic [11:0] result;
    logic [1:0] result_ch;

    logic       start_b, cont_b, cmp_b;
    logic [5:0] ph_len_b;
    logic [7:0] n_cyc_b;
    logic       PII1_b, PII2_b, PI1_b, PI2_b, src_n_b, snk_b, preChrg_b, busy_b, valid_b;
    logic [0:0] ch_sel_b;
    logic [3:0] result_b;
    logic [0:0] result_ch_b;

    int errors = 0;
    int checks = 0;
    int exp_ch = 0;

    tmp_seq_mc #(.N_CH(4), .PH_W(6), .CYC_W(8), .ACC_W(12)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .cont(cont), .cmp(cmp),
        .ph_len(ph_len), .n_cyc(n_cyc), .PII1(PII1), .PII2(PII2), .PI1(PI1), .PI2(PI2),
        .src_n(src_n), .snk(snk), .preChrg(preChrg), .ch_sel(ch_sel), .busy(busy),
        .valid(valid), .result(result), .result_ch(result_ch)
    );

    tmp_seq_mc #(.N_CH(1), .PH_W(6), .CYC_W(8), .ACC_W(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .cont(cont_b), .cmp(cmp_b),
        .ph_len(ph_len_b), .n_cyc(n_cyc_b), .PII1(PII1_b), .PII2(PII2_b), .PI1(PI1_b), .PI2(PI2_b),
        .src_n(src_n_b), .snk(snk_b), .preChrg(preChrg_b), .ch_sel(ch_sel_b), .busy(busy_b),
        .valid(valid_b), .result(result_b), .result_ch(result_ch_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Phase groups must never overlap and must be separated by at least one all-low cycle.
    int   prev_grp = 0;
    logic dio, big;
    always @(negedge clk) begin
        dio = PII1 | PII2;
        big = PI1 | PI2;
        checks++;
        if ((dio && big) || (dio && prev_grp == 2) || (big && prev_grp == 1) ||
            ((PII1_b | PII2_b) && (PI1_b | PI2_b))) begin
            errors++;
            $display("FAIL phase_excl: PII=%b%b PI=%b%b prev=%0d B:%b%b%b%b",
                     PII1, PII2, PI1, PI2, prev_grp, PII1_b, PII2_b, PI1_b, PI2_b);
        end
        prev_grp = dio ? 1 : (big ? 2 : 0);
    end

    // Cycle model: k counts edges after the one that took the start; diode/big-diode windows and
    // the src_n/snk loop follow from L, n and cmp directly.
    task automatic run_conv(input int L, input int n, input bit c, input int exp_t, input int exp_res,
                            input bit chained, input bit cont_in, input bit poke, input bit rearm,
                            input logic [5:0] raw_l, input logic [7:0] raw_n);
        int  P;
        int  j, r;
        bit  pii1, pii2, pi1, pi2;
        bit  m_snk, m_src;
        logic [8:0] exp_v, act_v;
        P = 2 * L + 2;
        m_snk = 1'b0;
        m_src = 1'b1;
        if (!chained) @(posedge clk);
        for (int k = 1; k <= exp_t; k++) begin
            @(negedge clk);
            start = rearm && (k == exp_t);
            cont  = cont_in;
            if (poke && k == 3) begin
                start  = 1'b1;
                ph_len = 6'($urandom_range(63));
                n_cyc  = 8'($urandom_range(255));
            end
            if (k == 4) begin
                ph_len = raw_l;
                n_cyc  = raw_n;
            end
            @(posedge clk);
            #1;
            j = k - 3;
            {pii1, pii2, pi1, pi2} = 4'b0000;
            if (j >= 0 && j < n * P) begin
                r = j % P;
                if (r < L) begin
                    pii1 = 1'b1;
                    pii2 = (r >= 1);
                end else if (r >= L + 1 && r <= 2 * L) begin
                    pi1 = 1'b1;
                    pi2 = (r >= L + 2);
                end
            end
            if (pi2) begin
                if (c) begin m_src = 1'b1; m_snk = !m_snk; end
                else   begin m_snk = 1'b0; m_src = !m_src; end
            end else begin
                m_snk = 1'b0;
                m_src = 1'b1;
            end
            exp_v = {pii1, pii2, pi1, pi2, m_src, m_snk, (k == 1), (k == exp_t), 1'b1};
            act_v = {PII1, PII2, PI1, PI2, src_n, snk, preChrg, valid, busy};
            check($sformatf("outputs L=%0d n=%0d k=%0d", L, n, k), act_v, exp_v);
        end
        check("result", result, exp_res);
        check("result_ch", result_ch, exp_ch);
        exp_ch = (exp_ch + 1) % 4;
    endtask

    task automatic idle_check();
        @(negedge clk);
        start = 1'b0;
        cont  = 1'b0;
        @(posedge clk);
        #1;
        check("idle valid/busy", {valid, busy}, 2'b00);
        check("ch_sel", ch_sel, 4'b0001 << exp_ch);
    endtask

    typedef struct {
        logic [5:0] ph;
        logic [7:0] nc;
        bit         c;
        bit         poke;
        int         exp_t;
        int         exp_res;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int L, n, T, res, seen;
        logic [5:0] rl;
        logic [7:0] rn;
        bit c, pk;

        tbl[0] = '{6'd3, 8'd4, 1'b1, 1'b0, 34, 4};
        tbl[1] = '{6'd3, 8'd4, 1'b0, 1'b0, 34, 0};
        tbl[2] = '{6'd0, 8'd0, 1'b1, 1'b0, 8,  1};
        tbl[3] = '{6'd5, 8'd2, 1'b1, 1'b1, 26, 4};
        tbl[4] = '{6'd4, 8'd3, 1'b1, 1'b1, 32, 6};
        tbl[5] = '{6'd1, 8'd1, 1'b0, 1'b0, 8,  0};

        reset_n = 1'b0;
        {start, cont, cmp} = 3'b000;
        ph_len = '0; n_cyc = '0;
        {start_b, cont_b, cmp_b} = 3'b000;
        ph_len_b = '0; n_cyc_b = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset outs", {PII1, PII2, PI1, PI2, src_n, snk, preChrg, valid, busy}, 9'b0000_1_0000);
        check("reset result", {result, result_ch}, '0);
        check("reset ch_sel", ch_sel, 4'b0001);
        check("reset B", {src_n_b, snk_b, preChrg_b, busy_b, valid_b, ch_sel_b}, 6'b100001);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            L = (tbl[i].ph < 2) ? 2 : int'(tbl[i].ph);
            n = (tbl[i].nc == 0) ? 1 : int'(tbl[i].nc);
            @(negedge clk);
            start = 1'b1; ph_len = tbl[i].ph; n_cyc = tbl[i].nc; cmp = tbl[i].c;
            run_conv(L, n, tbl[i].c, tbl[i].exp_t, tbl[i].exp_res, 1'b0, 1'b0, tbl[i].poke, 1'b0,
                     tbl[i].ph, tbl[i].nc);
            idle_check();
        end

        // start coinciding with DONE re-arms straight into the next conversion
        @(negedge clk);
        start = 1'b1; ph_len = 6'd2; n_cyc = 8'd2; cmp = 1'b1;
        run_conv(2, 2, 1'b1, 14, 2, 1'b0, 1'b0, 1'b0, 1'b1, 6'd2, 8'd2);
        run_conv(2, 2, 1'b1, 14, 2, 1'b1, 1'b0, 1'b0, 1'b0, 6'd2, 8'd2);
        idle_check();

        // continuous mode: five back-to-back conversions, cont dropped during the last
        @(negedge clk);
        start = 1'b0; cont = 1'b1; ph_len = 6'd3; n_cyc = 8'd1; cmp = 1'b1;
        for (int i = 0; i < 5; i++)
            run_conv(3, 1, 1'b1, 10, 1, (i != 0), (i < 4), 1'b0, 1'b0, 6'd3, 8'd1);
        idle_check();

        // reset in the middle of BIGDIODE
        @(negedge clk);
        start = 1'b1; ph_len = 6'd4; n_cyc = 8'd3; cmp = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("PI1 before reset", PI1, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid reset outs", {PII1, PII2, PI1, PI2, src_n, snk, preChrg, valid, busy}, 9'b0000_1_0000);
        check("mid reset regs", {result, result_ch, ch_sel}, {12'd0, 2'd0, 4'b0001});
        exp_ch = 0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (valid) seen = 1;
        end
        check("no valid after reset", seen, 0);
        @(negedge clk);
        start = 1'b1; ph_len = 6'd4; n_cyc = 8'd3; cmp = 1'b1;
        run_conv(4, 3, 1'b1, 32, 6, 1'b0, 1'b0, 1'b0, 1'b0, 6'd4, 8'd3);
        idle_check();

        for (int it = 0; it < 20; it++) begin
            rl = 6'($urandom_range(7));
            rn = 8'($urandom_range(4));
            c  = 1'($urandom_range(1));
            pk = 1'($urandom_range(1));
            L  = (rl < 2) ? 2 : int'(rl);
            n  = (rn == 0) ? 1 : int'(rn);
            T  = n * (2 * L + 2) + 2;
            res = c ? n * (L / 2) : 0;
            @(negedge clk);
            start = 1'b1; ph_len = rl; n_cyc = rn; cmp = c;
            run_conv(L, n, c, T, res, 1'b0, 1'b0, pk, 1'b0, rl, rn);
            idle_check();
        end

        // narrow accumulator saturates; single channel stays on index 0
        @(negedge clk);
        start_b = 1'b1; ph_len_b = 6'd2; n_cyc_b = 8'd20; cmp_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_b = 1'b0;
        seen = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (valid_b) begin
                seen = k;
                break;
            end
        end
        check("B latency", seen, 122);
        check("B result saturated", result_b, 4'd15);
        check("B result_ch", result_ch_b, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("B idle", {busy_b, valid_b, ch_sel_b}, 3'b001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
